wb_bus_arbiter: RTL and testbench
=================================

// Module: wb_bus_arbiter
// PURPOSE
//  Two-master Wishbone (pipelined) arbiter that shares the CPU's single bus port between
//  the instruction-fetch unit (m0) and the load/store memory unit (m1). It grants one owner
//  per bus cycle (CYC envelope) with round-robin fairness, and muxes the request and response
//  signals. A watchdog aborts stalled cycles with an error pulse. It sits between the CPU
//  phases and the SoC interconnect.
// PARAMETERS
//  AW          32   address width
//  DW          32   data width
//  TIMEOUT     255  max cycles an owner may wait for ACK after STB before abort (>=2)
//  TW          8    watchdog counter width; 2**TW > TIMEOUT
// PORTS
//  clk          in   1   clock, all logic on posedge
//  reset        in   1   asynchronous, active-high; clears all state
//  i_m0_cyc     in   1   fetch: bus cycle request/hold
//  i_m0_stb     in   1   fetch: strobe
//  i_m0_we      in   1   fetch: write enable
//  i_m0_addr    in   AW  fetch: address
//  i_m0_data    in   DW  fetch: write data
//  o_m0_ack     out  1   fetch: ACK, routed only while m0 owns the bus
//  o_m0_stall   out  1   fetch: stall; 1 whenever m0 is not the owner
//  o_m0_err     out  1   fetch: 1-cycle watchdog abort pulse
//  o_m0_data    out  DW  fetch: read data (i_wb_data, always passed through)
//  i_m1_* / o_m1_*       same set for the load/store unit
//  o_wb_cyc     out  1   slave CYC
//  o_wb_stb     out  1   slave STB
//  o_wb_we      out  1   slave WE
//  o_wb_addr    out  AW  slave address
//  o_wb_data    out  DW  slave write data
//  i_wb_ack     in   1   slave ACK
//  i_wb_stall   in   1   slave STALL
//  i_wb_data    in   DW  slave read data
// BEHAVIOUR
//  - Reset (asynchronous): state=IDLE, last=m1, watchdog=0. All outputs are 0 except
//    o_mX_stall=1 and o_mX_data=i_wb_data. Reset asserted mid-cycle drops o_wb_cyc at once.
//  - States: IDLE, OWN0, OWN1, ABORT. The state and the owner are registered.
//  - IDLE: if one i_mX_cyc is high -> OWNX next edge. If both are high -> grant the master
//    that is not `last`. Set last <= granted master. Grant latency is 1 clock from CYC.
//  - OWNX: o_wb_cyc=i_mX_cyc, o_wb_stb=i_mX_stb, and we/addr/data come from mX (combinational
//    mux). o_mX_ack=i_wb_ack, o_mX_stall=i_wb_stall. The other master sees stall=1, ack=0.
//  - OWNX -> IDLE when i_mX_cyc=0. No preemption while the owner holds CYC. Re-arbitration
//    costs one idle clock, so back-to-back requests alternate m0/m1 when both are pending.
//  - Outstanding count per owner: +1 on (stb & ~stall), -1 on ack. Simultaneous events give a
//    net 0. An ACK with count 0 is ignored, the count saturates at 0, and no ack is forwarded.
//  - Watchdog: cleared on any ACK or when count=0. It increments each OWN clock while
//    count>0. When it reaches TIMEOUT -> o_mX_err=1 for one clock, o_wb_cyc/stb forced to 0,
//    and state=ABORT.
//  - ABORT: bus outputs are 0 and the owner's stall is 1. Late slave ACKs are dropped. When
//    i_mX_cyc=0 -> IDLE.
//  - Outputs to the slave are never driven by a non-owner. In IDLE and ABORT o_wb_cyc=0.
// TESTING
//  - Single m0 read at 0xb0000000: cyc/stb@t0 -> o_wb_cyc@t1, addr=0xb0000000. Slave ack with
//    0xdeadbeef -> o_m0_ack=1 and data=0xdeadbeef. m1 stall=1 throughout.
//  - Simultaneous m0/m1 cyc after reset (last=m1) -> m0 granted first. On m0 cyc drop -> IDLE
//    for 1 clk, then m1 granted. A repeat gives m0 next (alternation).
//  - m1 push write 0x12345678 to 0xb000fffc while m0 requests -> m0 held stalled until m1
//    drops cyc. WE and data reach the slave unchanged.
//  - Slave never acks, TIMEOUT=255 -> o_m1_err pulses exactly 255 clks after stb accept.
//    CYC drops, a late ack is not forwarded, and IDLE is reached after m1 drops cyc.
//  - reset asserted mid-OWN0 with stb pending -> o_wb_cyc=0 the same cycle. After release,
//    state=IDLE and the first simultaneous request is granted to m0.
//  - Stray i_wb_ack in IDLE, or with count 0 -> no o_mX_ack, no state change.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Two-master pipelined Wishbone arbiter: round-robin grant per CYC envelope,
// request/response muxing, and a watchdog that aborts cycles stuck waiting for ACK.
module wb_bus_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255,
   parameter int TW      = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_m0_cyc,
   input  logic          i_m0_stb,
   input  logic          i_m0_we,
   input  logic [AW-1:0] i_m0_addr,
   input  logic [DW-1:0] i_m0_data,
   output logic          o_m0_ack,
   output logic          o_m0_stall,
   output logic          o_m0_err,
   output logic [DW-1:0] o_m0_data,
   input  logic          i_m1_cyc,
   input  logic          i_m1_stb,
   input  logic          i_m1_we,
   input  logic [AW-1:0] i_m1_addr,
   input  logic [DW-1:0] i_m1_data,
   output logic          o_m1_ack,
   output logic          o_m1_stall,
   output logic          o_m1_err,
   output logic [DW-1:0] o_m1_data,
   output logic          o_wb_cyc,
   output logic          o_wb_stb,
   output logic          o_wb_we,
   output logic [AW-1:0] o_wb_addr,
   output logic [DW-1:0] o_wb_data,
   input  logic          i_wb_ack,
   input  logic          i_wb_stall,
   input  logic [DW-1:0] i_wb_data
);

   // state | meaning
   // IDLE  | no owner, arbitrate pending CYC requests
   // OWN0  | fetch unit (m0) owns the bus
   // OWN1  | load/store unit (m1) owns the bus
   // ABORT | watchdog fired, wait for owner to drop CYC
   typedef enum logic [1:0] {S_IDLE, S_OWN0, S_OWN1, S_ABORT} state_t;

   state_t        state_q, state_d;
   logic          last_q, last_d;
   logic          owner_q, owner_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [TW-1:0] wdog_q, wdog_d;

   logic          own_cyc, own_stb, own_we, accept, ack_ok, in_own, timeout;
   logic [AW-1:0] own_addr;
   logic [DW-1:0] own_data;

   assign own_cyc  = owner_q ? i_m1_cyc  : i_m0_cyc;
   assign own_stb  = owner_q ? i_m1_stb  : i_m0_stb;
   assign own_we   = owner_q ? i_m1_we   : i_m0_we;
   assign own_addr = owner_q ? i_m1_addr : i_m0_addr;
   assign own_data = owner_q ? i_m1_data : i_m0_data;

   assign in_own  = (state_q == S_OWN0) || (state_q == S_OWN1);
   assign timeout = in_own && (wdog_q == TW'(TIMEOUT));
   assign accept  = own_cyc && own_stb && !i_wb_stall;
   // ACKs with nothing outstanding are stray and never reach a master
   assign ack_ok  = i_wb_ack && (cnt_q != '0);

   assign o_m0_data = i_wb_data;
   assign o_m1_data = i_wb_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         cnt_q   <= '0;
         wdog_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         wdog_q  <= wdog_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      owner_d    = owner_q;
      cnt_d      = '0;
      wdog_d     = '0;
      o_wb_cyc   = 1'b0;
      o_wb_stb   = 1'b0;
      o_wb_we    = 1'b0;
      o_wb_addr  = '0;
      o_wb_data  = '0;
      o_m0_ack   = 1'b0;
      o_m1_ack   = 1'b0;
      o_m0_stall = 1'b1;
      o_m1_stall = 1'b1;
      o_m0_err   = 1'b0;
      o_m1_err   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_m0_cyc && (!i_m1_cyc || last_q)) begin
               state_d = S_OWN0;
               owner_d = 1'b0;
               last_d  = 1'b0;
            end else if (i_m1_cyc) begin
               state_d = S_OWN1;
               owner_d = 1'b1;
               last_d  = 1'b1;
            end
         end
         S_OWN0, S_OWN1: begin
            if (timeout) begin
               o_m0_err = !owner_q;
               o_m1_err = owner_q;
               state_d  = S_ABORT;
            end else begin
               o_wb_cyc  = own_cyc;
               o_wb_stb  = own_cyc && own_stb;
               o_wb_we   = own_we;
               o_wb_addr = own_addr;
               o_wb_data = own_data;
               if (owner_q) begin
                  o_m1_ack   = ack_ok;
                  o_m1_stall = i_wb_stall;
               end else begin
                  o_m0_ack   = ack_ok;
                  o_m0_stall = i_wb_stall;
               end
               if (!own_cyc) begin
                  state_d = S_IDLE;
               end else begin
                  cnt_d  = cnt_q + TW'(accept) - TW'(ack_ok);
                  wdog_d = (i_wb_ack || cnt_q == '0) ? '0 : wdog_q + 1'b1;
               end
            end
         end
         S_ABORT: begin
            if (!own_cyc) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: directed bus sequences, read data checked through
// per-master expected-response queues popped whenever the arbiter forwards an ACK.
module tb_wb_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_m0_cyc, i_m0_stb, i_m0_we;
   logic [31:0] i_m0_addr, i_m0_data;
   logic        o_m0_ack, o_m0_stall, o_m0_err;
   logic [31:0] o_m0_data;
   logic        i_m1_cyc, i_m1_stb, i_m1_we;
   logic [31:0] i_m1_addr, i_m1_data;
   logic        o_m1_ack, o_m1_stall, o_m1_err;
   logic [31:0] o_m1_data;
   logic        o_wb_cyc, o_wb_stb, o_wb_we;
   logic [31:0] o_wb_addr, o_wb_data;
   logic        i_wb_ack, i_wb_stall;
   logic [31:0] i_wb_data;

   int          n_chk = 0;
   int          n_bad = 0;
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   int          n_err;
   logic        found;

   always #5 clk = ~clk;

   wb_bus_arbiter dut (
      .clk(clk), .reset(reset),
      .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we),
      .i_m0_addr(i_m0_addr), .i_m0_data(i_m0_data),
      .o_m0_ack(o_m0_ack), .o_m0_stall(o_m0_stall), .o_m0_err(o_m0_err), .o_m0_data(o_m0_data),
      .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we),
      .i_m1_addr(i_m1_addr), .i_m1_data(i_m1_data),
      .o_m1_ack(o_m1_ack), .o_m1_stall(o_m1_stall), .o_m1_err(o_m1_err), .o_m1_data(o_m1_data),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
      .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
      .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_data(i_wb_data)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Response scoreboard: every forwarded ACK must match the oldest expected response
   always @(negedge clk) begin
      if (!reset) begin
         if (o_m0_ack) begin
            if (q0.size() == 0) chk("m0_ack_unexpected", 32'(o_m0_ack), 0);
            else chk("m0_rdata", o_m0_data, q0.pop_front());
         end
         if (o_m1_ack) begin
            if (q1.size() == 0) chk("m1_ack_unexpected", 32'(o_m1_ack), 0);
            else chk("m1_rdata", o_m1_data, q1.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL sim_timeout got=running exp=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      reset = 1'b1;
      i_m0_cyc = 0; i_m0_stb = 0; i_m0_we = 0; i_m0_addr = 0; i_m0_data = 0;
      i_m1_cyc = 0; i_m1_stb = 0; i_m1_we = 0; i_m1_addr = 0; i_m1_data = 0;
      i_wb_ack = 0; i_wb_stall = 0; i_wb_data = 32'h5a5a5a5a;
      #2;
      chk("rst_cyc", 32'(o_wb_cyc), 0);
      chk("rst_m0_stall", 32'(o_m0_stall), 1);
      chk("rst_m1_stall", 32'(o_m1_stall), 1);
      chk("rst_m1_err", 32'(o_m1_err), 0);
      chk("rst_m0_data", o_m0_data, 32'h5a5a5a5a);
      tick; tick;
      reset = 1'b0;

      // simultaneous requests after reset: m0 first, then m1, then m0 again
      tick;
      i_m0_cyc = 1; i_m1_cyc = 1; #1;
      chk("grant_latency", 32'(o_wb_cyc), 0);
      tick;
      chk("arb0_m0_stall", 32'(o_m0_stall), 0);
      chk("arb0_m1_stall", 32'(o_m1_stall), 1);
      chk("arb0_cyc", 32'(o_wb_cyc), 1);
      i_m0_cyc = 0; #1;
      chk("own_cyc_follow", 32'(o_wb_cyc), 0);
      tick;
      chk("idle_gap_cyc", 32'(o_wb_cyc), 0);
      chk("idle_gap_m1_stall", 32'(o_m1_stall), 1);
      tick;
      chk("arb1_m1_stall", 32'(o_m1_stall), 0);
      chk("arb1_m0_stall", 32'(o_m0_stall), 1);
      i_m1_cyc = 0;
      tick;
      i_m0_cyc = 1; i_m1_cyc = 1;
      tick;
      chk("arb2_m0_stall", 32'(o_m0_stall), 0);
      chk("arb2_m1_stall", 32'(o_m1_stall), 1);
      i_m0_cyc = 0; i_m1_cyc = 0;
      tick;

      // single m0 read, slave stalls the first beat
      i_m0_cyc = 1; i_m0_stb = 1; i_m0_addr = 32'hb0000000; i_wb_stall = 1;
      tick;
      chk("rd_addr", o_wb_addr, 32'hb0000000);
      chk("rd_cyc", 32'(o_wb_cyc), 1);
      chk("rd_stb", 32'(o_wb_stb), 1);
      chk("rd_stall_pass", 32'(o_m0_stall), 1);
      i_wb_stall = 0; #1;
      chk("rd_m0_stall", 32'(o_m0_stall), 0);
      tick;
      i_m0_stb = 0; i_wb_ack = 1; i_wb_data = 32'hdeadbeef; q0.push_back(32'hdeadbeef); #1;
      chk("rd_ack", 32'(o_m0_ack), 1);
      chk("rd_m1_stall", 32'(o_m1_stall), 1);
      tick;
      i_wb_ack = 0; i_m0_cyc = 0;
      tick;

      // m1 write while m0 waits
      i_m1_cyc = 1; i_m1_stb = 1; i_m1_we = 1; i_m1_addr = 32'hb000fffc; i_m1_data = 32'h12345678;
      tick;
      i_m0_cyc = 1; i_m0_stb = 1; i_m0_addr = 32'hb0000010; #1;
      chk("wr_we", 32'(o_wb_we), 1);
      chk("wr_addr", o_wb_addr, 32'hb000fffc);
      chk("wr_data", o_wb_data, 32'h12345678);
      chk("wr_m0_stall", 32'(o_m0_stall), 1);
      tick;
      i_m1_stb = 0; i_m1_we = 0; i_wb_ack = 1; i_wb_data = 32'h0; q1.push_back(32'h0); #1;
      chk("wr_m0_held", 32'(o_m0_stall), 1);
      tick;
      i_wb_ack = 0; #1;
      chk("wr_m0_held2", 32'(o_m0_stall), 1);
      i_m1_cyc = 0;
      tick;
      chk("wr_gap_m0_stall", 32'(o_m0_stall), 1);
      tick;
      chk("wr_m0_grant", 32'(o_m0_stall), 0);
      chk("wr_m0_addr", o_wb_addr, 32'hb0000010);
      tick;
      i_m0_stb = 0; i_wb_ack = 1; i_wb_data = 32'hcafef00d; q0.push_back(32'hcafef00d);
      tick;
      i_wb_ack = 0; i_m0_cyc = 0;
      tick;

      // m1 read that the slave never acknowledges
      i_m1_cyc = 1; i_m1_stb = 1; i_m1_addr = 32'hb0000020;
      tick;
      tick;
      i_m1_stb = 0;
      n_err = 0; found = 0;
      for (int i = 1; i <= 300 && !found; i++) begin
         tick;
         if (o_m1_err) begin
            found = 1;
            n_err = i;
         end
      end
      chk("wdog_latency", n_err, 255);
      chk("to_cyc", 32'(o_wb_cyc), 0);
      chk("to_stb", 32'(o_wb_stb), 0);
      chk("to_m0_err", 32'(o_m0_err), 0);
      tick;
      chk("err_pulse_width", 32'(o_m1_err), 0);
      chk("abort_cyc", 32'(o_wb_cyc), 0);
      chk("abort_m1_stall", 32'(o_m1_stall), 1);
      i_wb_ack = 1; i_wb_data = 32'h11111111; #1;
      chk("late_ack", 32'(o_m1_ack), 0);
      tick;
      i_wb_ack = 0; #1;
      chk("abort_hold_cyc", 32'(o_wb_cyc), 0);
      i_m1_cyc = 0;
      tick;
      i_m0_cyc = 1;
      tick;
      chk("post_abort_grant", 32'(o_m0_stall), 0);

      // reset in the middle of an m0 cycle
      i_m0_stb = 1; #1;
      chk("pre_rst_cyc", 32'(o_wb_cyc), 1);
      reset = 1; #1;
      chk("rst_mid_cyc", 32'(o_wb_cyc), 0);
      chk("rst_mid_stb", 32'(o_wb_stb), 0);
      tick;
      i_m0_cyc = 0; i_m0_stb = 0; reset = 0;
      tick;
      i_m0_cyc = 1; i_m1_cyc = 1;
      tick;
      chk("post_rst_m0_grant", 32'(o_m0_stall), 0);
      chk("post_rst_m1_stall", 32'(o_m1_stall), 1);

      // stray ACK while owning with nothing outstanding
      i_wb_ack = 1; #1;
      chk("stray_own_ack", 32'(o_m0_ack), 0);
      tick;
      i_wb_ack = 0; #1;
      chk("stray_own_state", 32'(o_m0_stall), 0);
      i_m0_stb = 1;
      tick;
      i_m0_stb = 0; i_wb_ack = 1; i_wb_data = 32'h0badf00d; q0.push_back(32'h0badf00d);
      tick;
      chk("post_sat_ack", 32'(o_m0_ack), 0);
      tick;
      i_wb_ack = 0; i_m0_cyc = 0; i_m1_cyc = 0;
      tick;

      // stray ACK in IDLE
      i_wb_ack = 1; #1;
      chk("idle_stray_m0", 32'(o_m0_ack), 0);
      chk("idle_stray_m1", 32'(o_m1_ack), 0);
      chk("idle_stray_cyc", 32'(o_wb_cyc), 0);
      tick;
      i_wb_ack = 0; #1;
      chk("idle_stray_state", 32'(o_wb_cyc), 0);

      chk("q0_drained", 32'(q0.size()), 0);
      chk("q1_drained", 32'(q1.size()), 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
